ex_operand_stage: RTL

- ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the 32-bit execute ALU.
- Captures decoded fields each cycle and drives the ALU's alu_ctrl, src_A and src_B.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts a one-cycle bubble.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/fwd_mux.sv | 27 ++
 rtl/ex_operand_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, datapath sizes and operand-usage decode.
package cpu_pkg;

  localparam int N  = 32;
  localparam int RA = 4;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_MUL = 5'd3,
    OP_MOV = 5'd4,
    OP_AND = 5'd9,
    OP_OR  = 5'd10,
    OP_XOR = 5'd11,
    OP_NOT = 5'd12,
    OP_LDR = 5'd17,
    OP_STR = 5'd19,
    OP_JE  = 5'd25,
    OP_JGT = 5'd27,
    OP_JGE = 5'd28,
    OP_JLT = 5'd29,
    OP_JLE = 5'd30
  } alu_op_e;

  function automatic logic uses_rs1(input logic [4:0] op);
    return op != 5'd0;
  endfunction

  // STR always reads rs2 as store data, even though src_B carries the offset.
  function automatic logic uses_rs2(input logic [4:0] op, input logic use_imm);
    logic used;
    used = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR: used = !use_imm;
      OP_STR:                                        used = 1'b1;
      default:                                       used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass: newest in-flight result wins (MEM over WB), r0 always reads zero.
module fwd_mux #(
  parameter int N  = 32,
  parameter int RA = 4
) (
  input  logic [RA-1:0] rs,
  input  logic [N-1:0]  rs_data,
  input  logic [RA-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic [N-1:0]  mem_result,
  input  logic [RA-1:0] wb_rd,
  input  logic          wb_reg_write,
  input  logic [N-1:0]  wb_result,
  output logic [N-1:0]  fwd
);

  always_comb begin
    fwd = rs_data;
    if (rs == '0)
      fwd = '0;
    else if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs))
      fwd = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs))
      fwd = wb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use bubble insertion.
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int N  = 32,
  parameter int RA = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [4:0]    id_alu_ctrl,
  input  logic [RA-1:0] id_rs1,
  input  logic [RA-1:0] id_rs2,
  input  logic [RA-1:0] id_rd,
  input  logic [N-1:0]  id_rs1_data,
  input  logic [N-1:0]  id_rs2_data,
  input  logic [N-1:0]  id_imm,
  input  logic          id_use_imm,
  input  logic          id_reg_write,
  input  logic          hold_i,
  input  logic          flush_i,
  input  logic [RA-1:0] mem_rd,
  input  logic          mem_reg_write,
  input  logic [N-1:0]  mem_result,
  input  logic [RA-1:0] wb_rd,
  input  logic          wb_reg_write,
  input  logic [N-1:0]  wb_result,
  output logic          stall_o,
  output logic          ex_valid,
  output logic [4:0]    alu_ctrl,
  output logic [N-1:0]  src_A,
  output logic [N-1:0]  src_B,
  output logic [N-1:0]  ex_store_data,
  output logic [RA-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [CW-1:0] stall_count
);

  logic          ex_valid_reg;
  logic [4:0]    alu_ctrl_reg;
  logic [RA-1:0] rs1_reg, rs2_reg, rd_reg;
  logic [N-1:0]  rs1_data_reg, rs2_data_reg, imm_reg;
  logic          use_imm_reg, reg_write_reg;
  logic [CW-1:0] stall_count_reg;
  logic [N-1:0]  fwd_a, fwd_b;
  logic          load_en, take_id, stall_hit;

  assign ex_mem_read  = (alu_ctrl_reg == OP_LDR);
  assign ex_mem_write = (alu_ctrl_reg == OP_STR);

  always_comb begin
    stall_hit = 1'b0;
    if (!flush_i && ex_valid_reg && ex_mem_read && (rd_reg != '0) && id_valid)
      stall_hit = (uses_rs1(id_alu_ctrl) && (id_rs1 == rd_reg)) ||
                  (uses_rs2(id_alu_ctrl, id_use_imm) && (id_rs2 == rd_reg));
  end

  // Flush overrides hold; anything not taken from ID loads as an all-zero bubble.
  assign load_en = flush_i || !hold_i;
  assign take_id = !flush_i && !stall_hit && id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg    <= 1'b0;
      alu_ctrl_reg    <= '0;
      rs1_reg         <= '0;
      rs2_reg         <= '0;
      rd_reg          <= '0;
      rs1_data_reg    <= '0;
      rs2_data_reg    <= '0;
      imm_reg         <= '0;
      use_imm_reg     <= 1'b0;
      reg_write_reg   <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      if (load_en) begin
        ex_valid_reg  <= take_id;
        alu_ctrl_reg  <= take_id ? id_alu_ctrl  : '0;
        rs1_reg       <= take_id ? id_rs1       : '0;
        rs2_reg       <= take_id ? id_rs2       : '0;
        rd_reg        <= take_id ? id_rd        : '0;
        rs1_data_reg  <= take_id ? id_rs1_data  : '0;
        rs2_data_reg  <= take_id ? id_rs2_data  : '0;
        imm_reg       <= take_id ? id_imm       : '0;
        use_imm_reg   <= take_id && id_use_imm;
        reg_write_reg <= take_id && id_reg_write;
      end
      if (!hold_i && stall_hit && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  fwd_mux #(.N(N), .RA(RA)) u_fwd_a (
    .rs(rs1_reg), .rs_data(rs1_data_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .fwd(fwd_a)
  );

  fwd_mux #(.N(N), .RA(RA)) u_fwd_b (
    .rs(rs2_reg), .rs_data(rs2_data_reg),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .fwd(fwd_b)
  );

  assign stall_o       = stall_hit;
  assign ex_valid      = ex_valid_reg;
  assign alu_ctrl      = alu_ctrl_reg;
  assign src_A         = fwd_a;
  assign src_B         = use_imm_reg ? imm_reg : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_rd         = rd_reg;
  assign ex_reg_write  = reg_write_reg;
  assign stall_count   = stall_count_reg;

endmodule
